// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared single-cycle ALU.
// Each granted request takes IDLE -> EXEC -> RESP and returns a one-cycle response pulse.
module alu_arbiter #(
   parameter int unsigned RR_INIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_data,
   output logic        rsp0_zero,
   output logic        rsp0_sgn,
   output logic        rsp0_err,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_data,
   output logic        rsp1_zero,
   output logic        rsp1_sgn,
   output logic        rsp1_err,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_c,
   input  logic        alu_zero,
   input  logic        alu_sgn
);

   localparam int unsigned DW  = 32;
   localparam int unsigned OPW = 4;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                 state_q;
   logic                   prio_q;
   logic                   gnt_q;
   logic                   err_q;
   logic [OPW-1:0]         op_q;
   logic [DW-1:0]          a_q;
   logic [DW-1:0]          b_q;
   logic [1:0]             rsp_valid_q;
   logic [1:0][DW-1:0]     rsp_data_q;
   logic [1:0]             rsp_zero_q;
   logic [1:0]             rsp_sgn_q;
   logic [1:0]             rsp_err_q;

   logic                   gnt_d;
   logic                   hs;
   logic [OPW-1:0]         sel_op;
   logic [DW-1:0]          sel_a;
   logic [DW-1:0]          sel_b;

   function automatic logic legal_op(input logic [OPW-1:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0110,
         4'b0101, 4'b1000, 4'b1010, 4'b1011: legal_op = 1'b1;
         default:                            legal_op = 1'b0;
      endcase
   endfunction

   // Priority port wins only when both are requesting.
   always_comb begin
      gnt_d = 1'b0;
      if (req0_valid && req1_valid) gnt_d = prio_q;
      else                          gnt_d = req1_valid;
   end

   assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !gnt_d;
   assign req1_ready = !rst && (state_q == IDLE) && req1_valid &&  gnt_d;
   assign hs         = req0_ready || req1_ready;

   assign sel_op = gnt_d ? req1_op : req0_op;
   assign sel_a  = gnt_d ? req1_a  : req0_a;
   assign sel_b  = gnt_d ? req1_b  : req0_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         prio_q      <= 1'(RR_INIT);
         gnt_q       <= 1'b0;
         err_q       <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= '0;
         rsp_sgn_q   <= '0;
         rsp_err_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hs) begin
                  gnt_q   <= gnt_d;
                  err_q   <= !legal_op(sel_op);
                  op_q    <= legal_op(sel_op) ? sel_op : OPW'(0);
                  a_q     <= sel_a;
                  b_q     <= sel_b;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               // Illegal opcodes report a forced zero result regardless of the ALU.
               rsp_valid_q[gnt_q] <= 1'b1;
               rsp_data_q[gnt_q]  <= err_q ? DW'(0) : alu_c;
               rsp_zero_q[gnt_q]  <= err_q ? 1'b1 : alu_zero;
               rsp_sgn_q[gnt_q]   <= err_q ? 1'b0 : alu_sgn;
               rsp_err_q[gnt_q]   <= err_q;
               state_q            <= RESP;
            end
            RESP: begin
               rsp_valid_q <= '0;
               prio_q      <= !gnt_q;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;

   assign rsp0_valid = rsp_valid_q[0];
   assign rsp0_data  = rsp_data_q[0];
   assign rsp0_zero  = rsp_zero_q[0];
   assign rsp0_sgn   = rsp_sgn_q[0];
   assign rsp0_err   = rsp_err_q[0];
   assign rsp1_valid = rsp_valid_q[1];
   assign rsp1_data  = rsp_data_q[1];
   assign rsp1_zero  = rsp_zero_q[1];
   assign rsp1_sgn   = rsp_sgn_q[1];
   assign rsp1_err   = rsp_err_q[1];

endmodule
